// File: rtl/lifegame_uart_pkg.sv
// Shared definitions for the life-game UART command path.
// Contents:
//   ASCII_*         byte codes used by the command grammar and the acknowledge
//   parser_state_e  command-parser states
//   opcode_e        latched command opcode
package lifegame_uart_pkg;

    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_S  = 8'h53;
    localparam logic [7:0] ASCII_C  = 8'h43;
    localparam logic [7:0] ASCII_N  = 8'h4E;
    localparam logic [7:0] ASCII_Z  = 8'h5A;
    localparam logic [7:0] ASCII_K  = 8'h4B;
    localparam logic [7:0] ASCII_E  = 8'h45;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARG     = 3'd1,
        ST_EOL     = 3'd2,
        ST_DISCARD = 3'd3,
        ST_EXEC    = 3'd4,
        ST_RESP    = 3'd5
    } parser_state_e;

    typedef enum logic [1:0] {
        OP_SET  = 2'd0,
        OP_CLR  = 2'd1,
        OP_STEP = 2'd2,
        OP_ZAP  = 2'd3
    } opcode_e;

endpackage

// File: rtl/hex_nibble_decode.sv
// ASCII hex digit decoder (0-9, a-f, A-F).
// Ports:
//   data_i    byte to decode
//   is_hex_o  1 when data_i is a hex digit
//   nibble_o  digit value; 0 when is_hex_o=0
module hex_nibble_decode (
    input  logic [7:0] data_i,
    output logic       is_hex_o,
    output logic [3:0] nibble_o
);

    always_comb begin
        is_hex_o = 1'b0;
        nibble_o = 4'h0;
        if (data_i >= 8'h30 && data_i <= 8'h39) begin
            is_hex_o = 1'b1;
            nibble_o = data_i[3:0];
        end else if ((data_i >= 8'h61 && data_i <= 8'h66) ||
                     (data_i >= 8'h41 && data_i <= 8'h46)) begin
            // letters a-f / A-F have low nibble 1..6; +9 maps them to 10..15
            is_hex_o = 1'b1;
            nibble_o = data_i[3:0] + 4'd9;
        end
    end

endmodule

// File: rtl/uart_cell_cmd_parser.sv
// ASCII command-line parser that edits the life-game cell grid.
// Ports:
//   sys_clk, sys_rst      clock, synchronous active-high reset
//   rx_data, rx_valid     received byte stream (no backpressure)
//   cell_we/x/y/val       single-cell write port to grid memory
//   step_pulse            advance one generation
//   clear_pulse           clear the whole grid
//   tx_data/valid/ready   one-byte acknowledge ('K' / 'E')
//   busy, overrun         executing/responding; sticky dropped-byte flag
//   err_count             saturating count of 'E' acknowledges
//
// state   | meaning
// IDLE    | waiting for an opcode byte
// ARG     | collecting four hex digits xxyy
// EOL     | command complete, expecting LF
// DISCARD | malformed line, swallowing bytes until LF
// EXEC    | one-cycle action strobe
// RESP    | acknowledge offered until tx_ready
module uart_cell_cmd_parser #(
    parameter int GRID_W = 64,
    parameter int GRID_H = 64
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       cell_we,
    output logic [7:0] cell_x,
    output logic [7:0] cell_y,
    output logic       cell_val,
    output logic       step_pulse,
    output logic       clear_pulse,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       overrun,
    output logic [7:0] err_count
);

    import lifegame_uart_pkg::*;

    parser_state_e state_q, state_d;
    opcode_e       op_q, op_d;
    logic [15:0]   arg_q, arg_d;
    logic [1:0]    nib_q, nib_d;
    logic [7:0]    resp_q, resp_d;
    logic [7:0]    cell_x_q, cell_x_d;
    logic [7:0]    cell_y_q, cell_y_d;
    logic [7:0]    err_q, err_d;
    logic          ovr_q, ovr_d;

    logic          is_hex;
    logic [3:0]    nibble;
    logic          busy_w;
    logic          take;
    logic          is_lf;
    logic          op_is_cell;
    logic          in_range;

    hex_nibble_decode u_hex (
        .data_i   (rx_data),
        .is_hex_o (is_hex),
        .nibble_o (nibble)
    );

    assign busy_w     = (state_q == ST_EXEC) || (state_q == ST_RESP);
    // CR is consumed silently in every accepting state
    assign take       = rx_valid && !busy_w && (rx_data != ASCII_CR);
    assign is_lf      = (rx_data == ASCII_LF);
    assign op_is_cell = (op_q == OP_SET) || (op_q == OP_CLR);
    // 9-bit compare so a 256-cell grid admits every 8-bit coordinate
    assign in_range   = ({1'b0, arg_q[15:8]} < 9'(GRID_W)) &&
                        ({1'b0, arg_q[7:0]}  < 9'(GRID_H));

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        arg_d    = arg_q;
        nib_d    = nib_q;
        resp_d   = resp_q;
        cell_x_d = cell_x_q;
        cell_y_d = cell_y_q;
        err_d    = err_q;
        ovr_d    = ovr_q;

        if (rx_valid && busy_w) begin
            ovr_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (take) begin
                    case (rx_data)
                        ASCII_S:  begin state_d = ST_ARG; op_d = OP_SET;  nib_d = 2'd0; end
                        ASCII_C:  begin state_d = ST_ARG; op_d = OP_CLR;  nib_d = 2'd0; end
                        ASCII_N:  begin state_d = ST_EOL; op_d = OP_STEP; end
                        ASCII_Z:  begin state_d = ST_EOL; op_d = OP_ZAP;  end
                        ASCII_LF: state_d = ST_IDLE;
                        default:  state_d = ST_DISCARD;
                    endcase
                end
            end
            ST_ARG: begin
                if (take) begin
                    if (is_hex) begin
                        arg_d = {arg_q[11:0], nibble};
                        nib_d = nib_q + 2'd1;
                        if (nib_q == 2'd3) begin
                            state_d = ST_EOL;
                        end
                    end else if (is_lf) begin
                        state_d = ST_RESP;
                        resp_d  = ASCII_E;
                    end else begin
                        state_d = ST_DISCARD;
                    end
                end
            end
            ST_EOL: begin
                if (take) begin
                    if (!is_lf) begin
                        state_d = ST_DISCARD;
                    end else if (op_is_cell && !in_range) begin
                        state_d = ST_RESP;
                        resp_d  = ASCII_E;
                    end else begin
                        state_d = ST_EXEC;
                        if (op_is_cell) begin
                            cell_x_d = arg_q[15:8];
                            cell_y_d = arg_q[7:0];
                        end
                    end
                end
            end
            ST_DISCARD: begin
                if (take && is_lf) begin
                    state_d = ST_RESP;
                    resp_d  = ASCII_E;
                end
            end
            ST_EXEC: begin
                state_d = ST_RESP;
                resp_d  = ASCII_K;
            end
            ST_RESP: begin
                if (tx_ready) begin
                    state_d = ST_IDLE;
                    if (resp_q == ASCII_E && err_q != 8'hFF) begin
                        err_d = err_q + 8'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_SET;
            arg_q    <= 16'h0000;
            nib_q    <= 2'd0;
            resp_q   <= 8'h00;
            cell_x_q <= 8'h00;
            cell_y_q <= 8'h00;
            err_q    <= 8'h00;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            arg_q    <= arg_d;
            nib_q    <= nib_d;
            resp_q   <= resp_d;
            cell_x_q <= cell_x_d;
            cell_y_q <= cell_y_d;
            err_q    <= err_d;
            ovr_q    <= ovr_d;
        end
    end

    assign cell_we     = (state_q == ST_EXEC) && op_is_cell;
    assign cell_val    = (state_q == ST_EXEC) && (op_q == OP_SET);
    assign step_pulse  = (state_q == ST_EXEC) && (op_q == OP_STEP);
    assign clear_pulse = (state_q == ST_EXEC) && (op_q == OP_ZAP);
    assign cell_x      = cell_x_q;
    assign cell_y      = cell_y_q;
    assign tx_valid    = (state_q == ST_RESP);
    assign tx_data     = resp_q;
    assign busy        = busy_w;
    assign overrun     = ovr_q;
    assign err_count   = err_q;

endmodule

// File: tb/tb_uart_cell_cmd_parser.sv
// Testbench for uart_cell_cmd_parser: directed scenarios with literal
// expectations plus randomized command lines, all checked every cycle
// against a line-level reference model.
module tb_uart_cell_cmd_parser;

    localparam int GRID_W = 64;
    localparam int GRID_H = 64;
    localparam logic [7:0] LF = 8'h0A;
    localparam logic [7:0] CR = 8'h0D;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       tx_ready = 1'b1;
    logic       cell_we, cell_val, step_pulse, clear_pulse, tx_valid, busy, overrun;
    logic [7:0] cell_x, cell_y, tx_data, err_count;

    always #5 sys_clk = ~sys_clk;

    uart_cell_cmd_parser #(.GRID_W(GRID_W), .GRID_H(GRID_H)) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .cell_we     (cell_we),
        .cell_x      (cell_x),
        .cell_y      (cell_y),
        .cell_val    (cell_val),
        .step_pulse  (step_pulse),
        .clear_pulse (clear_pulse),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .overrun     (overrun),
        .err_count   (err_count)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            if (failures <= 50)
                $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (line level) ----------------
    logic       m_on = 1'b0;
    logic       m_we, m_val, m_step, m_clr, m_txv, m_ovr;
    logic [7:0] m_x, m_y, m_txd, m_err;
    logic [7:0] line_q[$];
    logic       exec_now, ok;
    logic [7:0] c0;
    int         d1, d2, d3, d4, xv, yv;

    function automatic int hexv(input logic [7:0] b);
        if (b >= 8'h30 && b <= 8'h39) return int'(b) - 48;
        if (b >= 8'h61 && b <= 8'h66) return int'(b) - 87;
        if (b >= 8'h41 && b <= 8'h46) return int'(b) - 55;
        return -1;
    endfunction

    initial forever begin
        @(posedge sys_clk);
        if (sys_rst) begin
            m_on = 1'b1;
            m_we = 0; m_val = 0; m_step = 0; m_clr = 0; m_txv = 0; m_ovr = 0;
            m_x = 0; m_y = 0; m_txd = 0; m_err = 0;
            line_q.delete();
        end else if (m_on) begin
            exec_now = m_we | m_step | m_clr;
            if ((exec_now || m_txv) && rx_valid) m_ovr = 1'b1;
            m_we = 0; m_val = 0; m_step = 0; m_clr = 0;
            if (exec_now) begin
                m_txv = 1'b1;
                m_txd = 8'h4B;
            end else if (m_txv) begin
                if (tx_ready) begin
                    m_txv = 1'b0;
                    if (m_txd == 8'h45 && m_err != 8'hFF) m_err = m_err + 8'd1;
                end
            end else if (rx_valid && rx_data != CR) begin
                if (rx_data != LF) begin
                    line_q.push_back(rx_data);
                end else begin
                    if (line_q.size() > 0) begin
                        ok = 1'b0;
                        c0 = line_q[0];
                        if ((c0 == 8'h4E || c0 == 8'h5A) && line_q.size() == 1) begin
                            ok = 1'b1;
                            if (c0 == 8'h4E) m_step = 1'b1; else m_clr = 1'b1;
                        end else if ((c0 == 8'h53 || c0 == 8'h43) && line_q.size() == 5) begin
                            d1 = hexv(line_q[1]); d2 = hexv(line_q[2]);
                            d3 = hexv(line_q[3]); d4 = hexv(line_q[4]);
                            if (d1 >= 0 && d2 >= 0 && d3 >= 0 && d4 >= 0) begin
                                xv = d1 * 16 + d2;
                                yv = d3 * 16 + d4;
                                if (xv < GRID_W && yv < GRID_H) begin
                                    ok = 1'b1;
                                    m_we = 1'b1;
                                    m_val = (c0 == 8'h53);
                                    m_x = 8'(xv);
                                    m_y = 8'(yv);
                                end
                            end
                        end
                        if (!ok) begin
                            m_txv = 1'b1;
                            m_txd = 8'h45;
                        end
                    end
                    line_q.delete();
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge sys_clk);
        if (m_on) begin
            chk("cell_we",     cell_we,     m_we);
            chk("cell_x",      cell_x,      m_x);
            chk("cell_y",      cell_y,      m_y);
            chk("cell_val",    cell_val,    m_val);
            chk("step_pulse",  step_pulse,  m_step);
            chk("clear_pulse", clear_pulse, m_clr);
            chk("tx_valid",    tx_valid,    m_txv);
            chk("tx_data",     tx_data,     m_txd);
            chk("busy",        busy,        m_we | m_step | m_clr | m_txv);
            chk("overrun",     overrun,     m_ovr);
            chk("err_count",   err_count,   m_err);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge sys_clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        tick(2);
        sys_rst = 1'b0;
    endtask

    function automatic logic [7:0] hexch(input int v);
        if (v < 10) return 8'(48 + v);
        if ($urandom_range(0, 1) == 0) return 8'(87 + v);
        return 8'(55 + v);
    endfunction

    logic [7:0] lb[$];
    string      s;

    task automatic send_str();
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind, n, len;
        @(posedge sys_clk);
        #1;
        do_reset();

        // Set (0x0A,0x05) alive
        tx_ready = 1'b1;
        s = "S0A05"; send_str(); send_byte(LF);
        chk("s1_we", cell_we, 1);
        chk("s1_x", cell_x, 8'h0A);
        chk("s1_y", cell_y, 8'h05);
        chk("s1_val", cell_val, 1);
        chk("s1_model_x", m_x, 8'h0A);
        tick(1);
        chk("s1_txv", tx_valid, 1);
        chk("s1_txd", tx_data, 8'h4B);
        tick(1);
        chk("s1_err", err_count, 0);
        chk("s1_txv_off", tx_valid, 0);

        // Clear (0x3F,0x3F) with CR and stalled transmitter
        do_reset();
        tx_ready = 1'b0;
        s = "C3f3F"; send_str(); send_byte(CR); send_byte(LF);
        chk("s2_we", cell_we, 1);
        chk("s2_x", cell_x, 8'h3F);
        chk("s2_y", cell_y, 8'h3F);
        chk("s2_val", cell_val, 0);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("s2_hold_txv", tx_valid, 1);
            chk("s2_hold_txd", tx_data, 8'h4B);
        end
        tx_ready = 1'b1;
        tick(1);
        chk("s2_accepted", tx_valid, 0);

        // x out of range
        do_reset();
        s = "S4000"; send_str(); send_byte(LF);
        chk("s3_no_we", cell_we, 0);
        chk("s3_txv", tx_valid, 1);
        chk("s3_txd", tx_data, 8'h45);
        chk("s3_model_txd", m_txd, 8'h45);
        tick(1);
        chk("s3_err", err_count, 1);

        // bad hex, then step, then clear
        do_reset();
        s = "SG1"; send_str(); send_byte(LF);
        chk("s4_txd_e", tx_data, 8'h45);
        tick(1);
        send_byte(8'h4E); send_byte(LF);
        chk("s4_step", step_pulse, 1);
        tick(1);
        chk("s4_step_off", step_pulse, 0);
        chk("s4_txd_k1", tx_data, 8'h4B);
        tick(1);
        send_byte(8'h5A); send_byte(LF);
        chk("s4_clear", clear_pulse, 1);
        tick(1);
        chk("s4_txd_k2", tx_data, 8'h4B);
        tick(1);
        chk("s4_err", err_count, 1);

        // bytes during RESP are dropped
        do_reset();
        tx_ready = 1'b0;
        send_byte(8'h4E); send_byte(LF);
        chk("s5_step", step_pulse, 1);
        send_byte(8'h5A);
        chk("s5_no_clear_a", clear_pulse, 0);
        send_byte(LF);
        chk("s5_no_clear_b", clear_pulse, 0);
        chk("s5_overrun", overrun, 1);
        chk("s5_txd", tx_data, 8'h4B);
        tx_ready = 1'b1;
        tick(1);
        chk("s5_released", tx_valid, 0);
        send_byte(8'h5A); send_byte(LF);
        chk("s5_clear", clear_pulse, 1);
        tick(1);
        chk("s5_txd2", tx_data, 8'h4B);
        tick(1);

        // reset mid-line
        s = "S0A05"; send_str(); send_byte(LF);
        tick(2);
        s = "S01"; send_str();
        sys_rst = 1'b1;
        tick(1);
        chk("s6_rst_x", cell_x, 0);
        chk("s6_rst_y", cell_y, 0);
        chk("s6_rst_ovr", overrun, 0);
        chk("s6_rst_txd", tx_data, 0);
        chk("s6_rst_txv", tx_valid, 0);
        chk("s6_rst_busy", busy, 0);
        chk("s6_rst_err", err_count, 0);
        tick(1);
        sys_rst = 1'b0;
        s = "02"; send_str(); send_byte(LF);
        chk("s6_txv", tx_valid, 1);
        chk("s6_txd", tx_data, 8'h45);
        tick(1);
        chk("s6_err", err_count, 1);

        // randomized lines
        do_reset();
        for (int line = 0; line < 300; line++) begin
            lb.delete();
            kind = $urandom_range(0, 7);
            case (kind)
                0, 1, 7: begin
                    lb.push_back(($urandom_range(0, 1) == 0) ? 8'h53 : 8'h43);
                    xv = (kind == 1) ? $urandom_range(0, 255) : $urandom_range(0, GRID_W - 1);
                    yv = (kind == 1) ? $urandom_range(0, 255) : $urandom_range(0, GRID_H - 1);
                    lb.push_back(hexch(xv / 16)); lb.push_back(hexch(xv % 16));
                    lb.push_back(hexch(yv / 16)); lb.push_back(hexch(yv % 16));
                    if (kind == 7) lb.push_back(hexch($urandom_range(0, 15)));
                end
                2: lb.push_back(8'h4E);
                3: lb.push_back(8'h5A);
                4: begin
                    lb.push_back(8'h53);
                    len = $urandom_range(0, 3);
                    for (int i = 0; i < len; i++) lb.push_back(hexch($urandom_range(0, 15)));
                end
                5: begin
                    len = $urandom_range(1, 6);
                    for (int i = 0; i < len; i++) lb.push_back(8'($urandom_range(32, 126)));
                end
                default: ;
            endcase
            foreach (lb[i]) begin
                if ($urandom_range(0, 7) == 0) send_byte(CR);
                tick($urandom_range(0, 2));
                send_byte(lb[i]);
            end
            send_byte(LF);
            if ((m_we | m_step | m_clr | m_txv) && $urandom_range(0, 3) == 0) begin
                tx_ready = 1'b0;
                repeat ($urandom_range(1, 2)) send_byte(8'($urandom_range(10, 126)));
            end
            n = 0;
            while ((m_we | m_step | m_clr | m_txv) && n < 200) begin
                tx_ready = ($urandom_range(0, 2) != 0);
                tick(1);
                n++;
            end
            if (n >= 200) begin
                checks++;
                failures++;
                $display("FAIL resp_timeout actual=busy required=idle t=%0t", $time);
            end
            tx_ready = 1'b1;
        end
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
